// File: rtl/riscv_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single downstream memory port.
// One transaction outstanding; data has priority, bounded by a fetch starvation counter.
module riscv_mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_ready,
  output logic            i_rvalid,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_valid,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic            d_write,
  output logic            d_ready,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            err
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t          r_state, w_state_nxt;
  logic [SW-1:0]   r_starve, w_starve_nxt;
  logic [XLEN-1:0] r_addr, r_wdata, r_i_rdata, r_d_rdata;
  logic            r_we, r_owner_d, r_i_rvalid, r_d_rvalid, r_err;
  logic            w_grant_i, w_grant_d, w_accept;

  // Ready is gated by rst so both readies read 0 while reset is held.
  always_comb begin
    w_grant_i = i_valid && (!d_valid || (r_starve == STARVE_LIM));
    w_grant_d = d_valid && !w_grant_i;
    w_accept  = (r_state == IDLE) && rst && (w_grant_i || w_grant_d);
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = REQ;
          if (w_grant_d && i_valid)
            w_starve_nxt = (r_starve == STARVE_LIM) ? r_starve : r_starve + 1'b1;
          else
            w_starve_nxt = '0;
        end
      end
      REQ:     if (mem_gnt)    w_state_nxt = RSP;
      RSP:     if (mem_rvalid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_owner_d  <= 1'b1;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      if (w_accept) begin
        r_addr    <= w_grant_i ? i_addr : d_addr;
        r_wdata   <= w_grant_i ? '0 : d_wdata;
        r_we      <= w_grant_d && d_write;
        r_owner_d <= w_grant_d;
      end
      if ((r_state == RSP) && mem_rvalid) begin
        if (r_owner_d) begin
          r_d_rdata  <= mem_rdata;
          r_d_rvalid <= 1'b1;
        end else begin
          r_i_rdata  <= mem_rdata;
          r_i_rvalid <= 1'b1;
        end
      end
      if (mem_rvalid && (r_state != RSP))
        r_err <= 1'b1;
    end
  end

  always_comb begin
    i_ready   = w_accept && w_grant_i;
    d_ready   = w_accept && w_grant_d;
    mem_req   = (r_state == REQ);
    mem_addr  = mem_req ? r_addr  : '0;
    mem_wdata = mem_req ? r_wdata : '0;
    mem_we    = mem_req && r_we;
    i_rvalid  = r_i_rvalid;
    d_rvalid  = r_d_rvalid;
    i_rdata   = r_i_rdata;
    d_rdata   = r_d_rdata;
    err       = r_err;
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: directed scenarios, then randomized
// traffic against a word-memory reference model and a behavioural arbiter model.
module tb_riscv_mem_arbiter;
  localparam int XLEN = 32;
  localparam int SMAX = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic i_valid = 0, i_ready, i_rvalid, d_valid = 0, d_write = 0, d_ready, d_rvalid;
  logic [31:0] i_addr = '0, i_rdata, d_addr = '0, d_wdata = '0, d_rdata;
  logic mem_req, mem_we, mem_gnt = 0, mem_rvalid = 0, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;

  riscv_mem_arbiter #(.XLEN(XLEN), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_write(d_write), .d_ready(d_ready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] addr; logic [31:0] wdata; logic we;} mreq_t;

  int n_checks = 0, n_fail = 0;
  logic [31:0] exp_i_q[$], exp_d_q[$];
  mreq_t exp_req_q[$];
  logic [31:0] golden[16], mem_arr[16];
  bit mem_auto = 0, m_busy = 0;
  logic [31:0] last_i = '0, last_d = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mem_complete(input logic [31:0] data);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = data;
    @(negedge clk);
    mem_rvalid = 0; mem_rdata = '0;
  endtask

  // Response monitor: every rvalid must match the head of that port's queue.
  always @(negedge rst) begin last_i = '0; last_d = '0; end
  always begin
    @(negedge clk); #2;
    if (rst) begin
      if (i_rvalid) begin
        if (exp_i_q.size() == 0) check("i_rvalid_unexpected", 1, 0);
        else begin last_i = exp_i_q.pop_front(); check("i_rdata", i_rdata, last_i); end
      end else check("i_rdata_hold", i_rdata, last_i);
      if (d_rvalid) begin
        if (exp_d_q.size() == 0) check("d_rvalid_unexpected", 1, 0);
        else begin last_d = exp_d_q.pop_front(); check("d_rdata", d_rdata, last_d); end
      end else check("d_rdata_hold", d_rdata, last_d);
      if (!mem_req) check("mem_idle_zero", mem_addr | mem_wdata | {31'b0, mem_we}, 0);
    end
  end

  // Randomized memory responder (active only in the random phase).
  mreq_t r_e;
  int r_gd, r_rd;
  logic [31:0] r_wcap, r_rdv;
  always begin
    @(negedge clk);
    if (mem_auto && rst) begin
      #1;
      if (mem_req) begin
        r_wcap = mem_wdata;
        if (exp_req_q.size() == 0) check("mem_req_unexpected", 1, 0);
        else begin
          r_e = exp_req_q.pop_front();
          check("mem_addr", mem_addr, r_e.addr);
          check("mem_wdata", mem_wdata, r_e.wdata);
          check("mem_we", mem_we, r_e.we);
        end
        r_gd = $urandom_range(0, 3);
        repeat (r_gd) begin
          @(negedge clk); #1;
          check("stall_req", mem_req, 1);
          check("stall_addr", mem_addr, r_e.addr);
        end
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        r_rd = $urandom_range(0, 3);
        repeat (r_rd) @(negedge clk);
        r_rdv = r_e.we ? 32'h0 : mem_arr[r_e.addr[5:2]];
        if (r_e.we) mem_arr[r_e.addr[5:2]] = r_wcap;
        mem_rvalid = 1; mem_rdata = r_rdv;
        @(negedge clk);
        mem_rvalid = 0; mem_rdata = $urandom; m_busy = 0;
      end
    end
  end

  logic [1:0] exp_g;
  logic [31:0] v;
  logic [3:0] idx_i, idx_d;
  bit acc_i, acc_d;
  int m_starve;

  initial begin
    for (int k = 0; k < 16; k++) begin
      golden[k]  = 32'hA500_0000 + k * 32'h0101_0101;
      mem_arr[k] = 32'hA500_0000 + k * 32'h0101_0101;
    end
    // Reset state, with both requesters asserting.
    i_valid = 1; d_valid = 1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_i_ready", i_ready, 0); check("rst_d_ready", d_ready, 0);
    check("rst_mem_req", mem_req, 0); check("rst_err", err, 0);
    check("rst_rvalid", {i_rvalid, d_rvalid}, 0); check("rst_rdata", i_rdata | d_rdata, 0);
    @(negedge clk); i_valid = 0; d_valid = 0; rst = 1;

    // Single fetch, minimum latency.
    @(negedge clk); i_valid = 1; i_addr = 32'h100;
    #1 check("f_i_ready", i_ready, 1); check("f_d_ready", d_ready, 0);
    exp_i_q.push_back(32'hDEADBEEF);
    @(negedge clk); i_valid = 0;
    #1 check("f_mem_req", mem_req, 1); check("f_mem_addr", mem_addr, 32'h100);
    check("f_mem_we", mem_we, 0); check("f_mem_wdata", mem_wdata, 0);
    mem_complete(32'hDEADBEEF);
    #1 check("f_latency", {i_rvalid, d_rvalid}, 2'b10);

    // Collision: data store wins, fetch follows.
    @(negedge clk); i_valid = 1; i_addr = 32'h200;
    d_valid = 1; d_write = 1; d_addr = 32'h40; d_wdata = 32'h5;
    #1 check("c_ready", {i_ready, d_ready}, 2'b01);
    exp_d_q.push_back(32'h0);
    @(negedge clk); d_valid = 0; d_write = 0;
    #1 check("c_mem_req", mem_req, 1); check("c_mem_we", mem_we, 1);
    check("c_mem_addr", mem_addr, 32'h40); check("c_mem_wdata", mem_wdata, 32'h5);
    check("c_i_ready_busy", i_ready, 0);
    mem_complete(32'h0);
    #1 check("c_d_rvalid", d_rvalid, 1); check("c_i_ready_after", i_ready, 1);
    exp_i_q.push_back(32'h12345678);
    @(negedge clk); i_valid = 0;
    #1 mem_complete(32'h12345678);

    // Starvation: D,D,D,D,I,D,D,D,D,I with both held high.
    i_valid = 1; d_valid = 1; d_write = 0;
    for (int g = 0; g < 10; g++) begin
      i_addr = 32'h300 + g * 4; d_addr = 32'h400 + g * 4; v = 32'hC000_0000 + g;
      #1 check("starve_order", {i_ready, d_ready}, (g == 4 || g == 9) ? 2'b10 : 2'b01);
      if (g == 4 || g == 9) exp_i_q.push_back(v); else exp_d_q.push_back(v);
      @(negedge clk);
      #1 check("starve_busy", {i_ready, d_ready}, 2'b00);
      mem_complete(v);
    end
    i_valid = 0; d_valid = 0;

    // Grant stall for 5 cycles with a waiting fetch.
    d_valid = 1; d_write = 1; d_addr = 32'h80; d_wdata = 32'h77;
    #1 check("g_d_ready", d_ready, 1);
    exp_d_q.push_back(32'h0);
    @(negedge clk); d_valid = 0; d_write = 0; i_valid = 1; i_addr = 32'h104;
    for (int k = 0; k < 5; k++) begin
      #1 check("g_mem_req", mem_req, 1); check("g_mem_addr", mem_addr, 32'h80);
      check("g_no_ready", {i_ready, d_ready}, 2'b00);
      @(negedge clk);
    end
    #1 mem_complete(32'h0);
    #1 check("g_i_ready", i_ready, 1);
    exp_i_q.push_back(32'hFEEDF00D);
    @(negedge clk); i_valid = 0;
    #1 mem_complete(32'hFEEDF00D);

    // Reset while waiting for the response; a late response must raise err.
    d_valid = 1; d_addr = 32'h44;
    #1 check("r_d_ready", d_ready, 1);
    @(negedge clk); d_valid = 0; mem_gnt = 1;
    @(negedge clk); mem_gnt = 0;
    #3 rst = 0;
    #1 check("r_mem_req", mem_req, 0); check("r_err_clear", err, 0);
    @(negedge clk); rst = 1; mem_rvalid = 1; mem_rdata = 32'h55;
    @(negedge clk); mem_rvalid = 0;
    #1 check("r_err_set", err, 1); check("r_no_rvalid", {i_rvalid, d_rvalid}, 2'b00);
    @(negedge clk); i_valid = 1; i_addr = 32'h108;
    #1 check("r_idle", i_ready, 1);
    exp_i_q.push_back(32'h600D);
    @(negedge clk); i_valid = 0;
    #1 mem_complete(32'h600D);

    // Asynchronous reset clears err mid-cycle; then a spurious response in IDLE.
    #3 rst = 0;
    #1 check("a_err_async", err, 0); check("a_rdata_async", i_rdata, 0);
    @(negedge clk); rst = 1; mem_rvalid = 1; mem_rdata = 32'h99;
    @(negedge clk); mem_rvalid = 0;
    #1 check("s_err_set", err, 1);
    repeat (3) @(negedge clk);
    #1 check("s_err_sticky", err, 1);

    // Randomized traffic.
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1; mem_auto = 1; m_starve = 0; acc_i = 0; acc_d = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (acc_i) begin i_valid = 0; acc_i = 0; end
      if (acc_d) begin d_valid = 0; acc_d = 0; end
      if (!i_valid && $urandom_range(0, 2) == 0) begin
        i_valid = 1; idx_i = 4'($urandom_range(0, 15)); i_addr = {26'b0, idx_i, 2'b00};
      end
      if (!d_valid && $urandom_range(0, 2) == 0) begin
        d_valid = 1; idx_d = 4'($urandom_range(0, 15)); d_addr = {26'b0, idx_d, 2'b00};
        d_write = 1'($urandom_range(0, 1)); d_wdata = $urandom;
      end
      #1;
      if (m_busy) exp_g = 2'b00;
      else if (i_valid && d_valid) exp_g = (m_starve == SMAX) ? 2'b10 : 2'b01;
      else exp_g = {i_valid, d_valid};
      check("arb_ready", {i_ready, d_ready}, exp_g);
      if (exp_g == 2'b10) begin
        exp_req_q.push_back('{addr: i_addr, wdata: 32'h0, we: 1'b0});
        exp_i_q.push_back(golden[idx_i]);
        m_starve = 0; m_busy = 1; acc_i = 1;
      end else if (exp_g == 2'b01) begin
        exp_req_q.push_back('{addr: d_addr, wdata: d_wdata, we: d_write});
        if (d_write) begin golden[idx_d] = d_wdata; exp_d_q.push_back(32'h0); end
        else exp_d_q.push_back(golden[idx_d]);
        m_starve = i_valid ? m_starve + 1 : 0; m_busy = 1; acc_d = 1;
      end
    end
    @(negedge clk); i_valid = 0; d_valid = 0;
    for (int k = 0; k < 100 && (m_busy || exp_i_q.size() != 0 || exp_d_q.size() != 0); k++)
      @(negedge clk);
    repeat (2) @(negedge clk);
    #3 check("drain", {m_busy, exp_i_q.size() != 0, exp_d_q.size() != 0, exp_req_q.size() != 0}, 0);
    check("final_err", err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
